// File: rtl/keccak_squeeze.sv
// SHAKE256 squeeze controller: streams 64-bit rate lanes from a permuted
// Keccak state and requests further permutations when the rate is exhausted.
module keccak_squeeze #(
  parameter int unsigned RATE_WORDS = 17,
  parameter int unsigned LEN_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1599:0]     state_in,
  input  logic [LEN_W-1:0]  out_len,
  output logic [63:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              done,
  output logic              busy,
  output logic              perm_req,
  output logic [1599:0]     perm_state,
  input  logic              perm_ack,
  input  logic [1599:0]     perm_result
);

  localparam int unsigned IDX_W  = $clog2(RATE_WORDS);
  localparam int unsigned BASE_W = 11;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    EMIT      = 2'd1,
    PERM_REQ  = 2'd2,
    PERM_WAIT = 2'd3
  } fsm_t;

  fsm_t              fsm;
  logic [1599:0]     st;
  logic [IDX_W-1:0]  word_idx;
  logic [LEN_W-1:0]  remaining;
  logic              done_r;
  logic [BASE_W-1:0] lane_base;

  // Sequencing of the squeeze; flags below are registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm       <= IDLE;
      st        <= '0;
      word_idx  <= '0;
      remaining <= '0;
      done_r    <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      perm_req  <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      perm_req <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            if (out_len != '0) begin
              st        <= state_in;
              remaining <= out_len;
              word_idx  <= '0;
              fsm       <= EMIT;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              done_r <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (remaining == LEN_W'(1)) begin
              fsm       <= IDLE;
              done_r    <= 1'b1;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end else if (word_idx == IDX_W'(RATE_WORDS - 1)) begin
              word_idx  <= '0;
              remaining <= remaining - LEN_W'(1);
              fsm       <= PERM_REQ;
              out_valid <= 1'b0;
              perm_req  <= 1'b1;
            end else begin
              word_idx  <= word_idx + IDX_W'(1);
              remaining <= remaining - LEN_W'(1);
            end
          end
        end
        PERM_REQ: begin
          fsm <= PERM_WAIT;
        end
        PERM_WAIT: begin
          // word_idx was already cleared at the block boundary
          if (perm_ack) begin
            st        <= perm_result;
            fsm       <= EMIT;
            out_valid <= 1'b1;
          end
        end
        default: begin
          fsm       <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

  assign lane_base  = BASE_W'(word_idx) << 6;
  assign out_data   = st[lane_base +: 64];
  assign out_last   = out_valid && (remaining == LEN_W'(1));
  assign done       = done_r;
  assign perm_state = st;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: table-driven handshake vectors plus
// sequences for full blocks, permutation round trips and reset aborts.
module tb_keccak_squeeze;

  logic          clock;
  logic          reset;
  logic          start;
  logic [1599:0] state_in;
  logic [15:0]   out_len;
  logic [63:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          done;
  logic          busy;
  logic          perm_req;
  logic [1599:0] perm_state;
  logic          perm_ack;
  logic [1599:0] perm_result;

  logic          ack_tbl;
  logic          model_ack;
  logic          model_en;
  int            model_cnt;
  int            preq_cnt;

  int checks;
  int failures;

  localparam logic [63:0] BASE_A = 64'h0;
  localparam logic [63:0] BASE_B = 64'hB000_0000_0000_0000;
  localparam logic [63:0] BASE_C = 64'hC000_0000_0000_0000;

  logic [1599:0] st_a;
  logic [1599:0] st_c;

  keccak_squeeze #(.RATE_WORDS(17), .LEN_W(16)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .state_in    (state_in),
    .out_len     (out_len),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .done        (done),
    .busy        (busy),
    .perm_req    (perm_req),
    .perm_state  (perm_state),
    .perm_ack    (perm_ack),
    .perm_result (perm_result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign perm_ack = ack_tbl | model_ack;

  // Permutation core model: acks 24 cycles after each perm_req pulse.
  always @(posedge clock) begin
    if (model_cnt != 0) begin
      model_cnt <= model_cnt - 1;
      model_ack <= (model_cnt == 1);
    end else begin
      model_ack <= 1'b0;
    end
    if (perm_req && model_en) model_cnt <= 23;
  end

  always @(posedge clock) if (perm_req) preq_cnt <= preq_cnt + 1;

  function automatic logic [1599:0] make_state(input logic [63:0] base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = base + 64'(i);
    return s;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input logic s, input logic [15:0] len, input logic sel,
                      input logic rdy, input logic ack);
    start     = s;
    out_len   = len;
    state_in  = sel ? st_c : st_a;
    out_ready = rdy;
    ack_tbl   = ack;
    @(posedge clock);
    #1;
    start   = 1'b0;
    ack_tbl = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_last"}, 64'(out_last), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_preq"}, 64'(perm_req), 64'd0);
    chk({tag, "_data"}, out_data, 64'd0);
    chk({tag, "_pstate"}, 64'(|perm_state), 64'd0);
  endtask

  task automatic short_stream(input string tag);
    tick(1'b1, 16'd2, 1'b0, 1'b1, 1'b0);
    chk({tag, "_v0"}, 64'(out_valid), 64'd1);
    chk({tag, "_d0"}, out_data, BASE_A);
    chk({tag, "_l0"}, 64'(out_last), 64'd0);
    tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_d1"}, out_data, BASE_A + 64'd1);
    chk({tag, "_l1"}, 64'(out_last), 64'd1);
    tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_vend"}, 64'(out_valid), 64'd0);
  endtask

  typedef struct {
    logic        s;
    logic [15:0] len;
    logic        sel;
    logic        rdy;
    logic        ack;
    logic        ev;
    logic [63:0] ed;
    logic        el;
    logic        edn;
    logic        eb;
  } vec_t;

  function automatic vec_t v(input int s, input int len, input int sel, input int rdy,
                             input int ack, input int ev, input int ed, input int el,
                             input int edn, input int eb);
    vec_t r;
    r.s = 1'(s); r.len = 16'(len); r.sel = 1'(sel); r.rdy = 1'(rdy); r.ack = 1'(ack);
    r.ev = 1'(ev); r.ed = 64'(ed); r.el = 1'(el); r.edn = 1'(edn); r.eb = 1'(eb);
    return r;
  endfunction

  vec_t tbl [21];

  initial begin
    checks = 0; failures = 0;
    model_cnt = 0; model_ack = 1'b0; model_en = 1'b0; preq_cnt = 0;
    st_a = make_state(BASE_A);
    st_c = make_state(BASE_C);
    perm_result = make_state(BASE_B);
    start = 1'b0; out_len = '0; out_ready = 1'b0; ack_tbl = 1'b0;
    state_in = st_a;

    //            s len sel rdy ack  ev ed el dn bz
    tbl[0]  = v(1, 3, 0, 1, 0,  1, 0, 0, 0, 1);
    tbl[1]  = v(0, 0, 0, 1, 0,  1, 1, 0, 0, 1);
    tbl[2]  = v(0, 0, 0, 1, 0,  1, 2, 1, 0, 1);
    tbl[3]  = v(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    tbl[4]  = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[5]  = v(1, 5, 0, 0, 0,  1, 0, 0, 0, 1);
    tbl[6]  = v(0, 0, 0, 1, 1,  1, 1, 0, 0, 1);
    tbl[7]  = v(0, 0, 0, 0, 0,  1, 1, 0, 0, 1);
    tbl[8]  = v(0, 0, 0, 0, 1,  1, 1, 0, 0, 1);
    tbl[9]  = v(0, 0, 0, 1, 0,  1, 2, 0, 0, 1);
    tbl[10] = v(0, 0, 0, 1, 0,  1, 3, 0, 0, 1);
    tbl[11] = v(0, 0, 0, 0, 0,  1, 3, 0, 0, 1);
    tbl[12] = v(0, 0, 0, 1, 0,  1, 4, 1, 0, 1);
    tbl[13] = v(0, 0, 0, 0, 0,  1, 4, 1, 0, 1);
    tbl[14] = v(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);
    tbl[15] = v(1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tbl[16] = v(0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[17] = v(1, 2, 0, 0, 0,  1, 0, 0, 0, 1);
    tbl[18] = v(1, 9, 1, 0, 0,  1, 0, 0, 0, 1);
    tbl[19] = v(0, 0, 0, 1, 0,  1, 1, 1, 0, 1);
    tbl[20] = v(0, 0, 0, 1, 0,  0, 0, 0, 1, 0);

    // Reset state
    reset = 1'b1;
    @(posedge clock); @(posedge clock); #1;
    chk_zero("reset");
    reset = 1'b0;

    // Table: short request, backpressure with spurious acks, zero length, start while busy
    for (int i = 0; i < 21; i++) begin
      tick(tbl[i].s, tbl[i].len, tbl[i].sel, tbl[i].rdy, tbl[i].ack);
      chk($sformatf("row%0d_valid", i), 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk($sformatf("row%0d_data", i), out_data, tbl[i].ed);
      chk($sformatf("row%0d_last", i), 64'(out_last), 64'(tbl[i].el));
      chk($sformatf("row%0d_done", i), 64'(done), 64'(tbl[i].edn));
      chk($sformatf("row%0d_busy", i), 64'(busy), 64'(tbl[i].eb));
      chk($sformatf("row%0d_preq", i), 64'(perm_req), 64'd0);
    end

    // One full block ending on the boundary: no permutation request
    tick(1'b1, 16'd17, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("blk17_v%0d", i), 64'(out_valid), 64'd1);
      chk($sformatf("blk17_d%0d", i), out_data, BASE_A + 64'(i));
      chk($sformatf("blk17_l%0d", i), 64'(out_last), 64'(i == 16));
      chk($sformatf("blk17_p%0d", i), 64'(perm_req), 64'd0);
      tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("blk17_done", 64'(done), 64'd1);
    chk("blk17_vend", 64'(out_valid), 64'd0);
    chk("blk17_preq", 64'(perm_req), 64'd0);
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("blk17_done_once", 64'(done), 64'd0);
    chk("blk17_preq_total", 64'(preq_cnt), 64'd0);

    // Twenty words: crosses a block boundary through the core model
    begin
      int n;
      int p0;
      p0 = preq_cnt;
      model_en = 1'b1;
      tick(1'b1, 16'd20, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 17; i++) begin
        chk($sformatf("blk20_d%0d", i), out_data, BASE_A + 64'(i));
        chk($sformatf("blk20_l%0d", i), 64'(out_last), 64'd0);
        tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      end
      chk("blk20_preq", 64'(perm_req), 64'd1);
      chk("blk20_vlow", 64'(out_valid), 64'd0);
      chk("blk20_busy", 64'(busy), 64'd1);
      n = 0;
      while (!out_valid && n < 60) begin
        tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
        chk($sformatf("blk20_gap_preq%0d", n), 64'(perm_req), 64'd0);
        n++;
      end
      chk("blk20_gap_len", 64'(n), 64'd25);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("blk20_rv%0d", i), 64'(out_valid), 64'd1);
        chk($sformatf("blk20_rd%0d", i), out_data, BASE_B + 64'(i));
        chk($sformatf("blk20_rl%0d", i), 64'(out_last), 64'(i == 2));
        tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
      end
      chk("blk20_done", 64'(done), 64'd1);
      chk("blk20_vend", 64'(out_valid), 64'd0);
      chk("blk20_preq_total", 64'(preq_cnt - p0), 64'd1);
      model_en = 1'b0;
      tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    end

    // Reset during EMIT on word 5 of 20
    tick(1'b1, 16'd20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_emit_word5", out_data, BASE_A + 64'd5);
    reset = 1'b1;
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("rst_emit");
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_emit_late_ack_valid", 64'(out_valid), 64'd0);
    chk("rst_emit_late_ack_busy", 64'(busy), 64'd0);
    chk("rst_emit_late_ack_done", 64'(done), 64'd0);
    short_stream("rst_emit_new");

    // Reset during PERM_WAIT
    tick(1'b1, 16'd20, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 17; i++) tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    tick(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    chk("rst_wait_busy", 64'(busy), 64'd1);
    chk("rst_wait_vlow", 64'(out_valid), 64'd0);
    reset = 1'b1;
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    chk_zero("rst_wait");
    tick(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    chk("rst_wait_late_ack_valid", 64'(out_valid), 64'd0);
    chk("rst_wait_late_ack_busy", 64'(busy), 64'd0);
    chk("rst_wait_late_ack_pstate", 64'(|perm_state), 64'd0);
    short_stream("rst_wait_new");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
